z80_mem_arbiter: RTL and testbench
==================================

# z80_mem_arbiter

Two-master memory bus controller for the Z80 system. It arbitrates between the CPU core and a DMA engine, and sequences one memory transaction at a time onto the shared memory bus. For each transaction it drives `MREQ_L`, `RD_L` and `WR_L`, owns `addr_bus`, and drives `data_bus` only during writes. It sits between the masters and the byte-wide `memory` model, which registers read data one clock after `RD_L` is seen low.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles the strobes stay asserted beyond the first access cycle. Legal range 1..15; elaboration error outside it.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_L` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU requests a transaction; held until `cpu_done`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr` in 16: CPU address; stable while `cpu_req`.
- `cpu_wdata` in 8: CPU write data; stable while `cpu_req`.
- `cpu_gnt` out 1: CPU owns the bus (ACCESS and RECOVER states).
- `cpu_done` out 1: one-cycle completion pulse.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_done`: identical set for the DMA master.
- `rdata` out 8: captured read data; valid while `*_done` is high and held until the next capture.
- `MREQ_L`, `RD_L`, `WR_L` out 1: memory strobes, active-low.
- `addr_bus` inout 16: driven with the granted address in ACCESS and RECOVER, else `'z`.
- `data_bus` inout 8: driven with write data in ACCESS of a write, else `'z`.

## Operation
- FSM states:
  - IDLE: strobes high, buses `'z`.
  - ACCESS: `MREQ_L`=0, `RD_L`=`we`, `WR_L`=`~we`.
  - RECOVER: strobes high; `*_done`=1 for the owner.
- IDLE→ACCESS on any sampled `*_req`. At that edge the arbiter latches owner, `we`, `addr`, `wdata` and loads `cnt` ← `WAIT_CYCLES`.
- ACCESS with `cnt`≠0: `cnt` decrements.
- ACCESS with `cnt`=0 → RECOVER. On a read, `rdata` ← `data_bus` at this edge.
- RECOVER → IDLE unconditionally.
- Latched request fields are used for the whole transaction; master changes after grant are ignored.
- Arbitration applies in IDLE only.
  - Single requester wins.
  - Both requesting: resolved per Configuration.
  - `last_owner` updates on IDLE→ACCESS.
- A master must drop `req` in the cycle its `done` is high. A `req` still high in the following IDLE starts a new transaction.
- Strobes are registered outputs, never combinational from `*_req`.
- Reset values:
  - `MREQ_L`/`RD_L`/`WR_L` = 1; buses `'z`.
  - `*_gnt`, `*_done` = 0; `rdata` = 8'h00.
  - state IDLE; `last_owner` = DMA, so the CPU wins the first tie.
- Reset mid-transaction: strobes deassert and buses release asynchronously. No `done` is issued; the transaction is lost, and the master re-requests after reset.

## Timing
- Request sampled at edge E0. Strobes are low from E0 through E(1+`WAIT_CYCLES`).
- Read data is captured at E(1+`WAIT_CYCLES`). `done` is high for exactly one cycle after that edge.
- Transaction occupancy: `WAIT_CYCLES`+2 cycles. Earliest next grant is at E(`WAIT_CYCLES`+3).
- With `WAIT_CYCLES`=1:
  - Read: strobes low 2 cycles; memory output valid after E1; capture at E2.
  - Write: `data_bus` held across E1 and E2, so the memory write enable set at E1 captures at E2.
- `*_gnt` rises the cycle after E0 and falls when RECOVER exits.

## Configuration
- `Z80_ARB_ROUND_ROBIN_EN` defined: on a tie, grant the master that is not `last_owner`.
- Undefined: fixed priority, CPU always wins ties; DMA can starve under back-to-back CPU traffic. `last_owner` logic is compiled out.

## Structure
- `z80_bus_pkg`: `arb_state_t` enum (IDLE, ACCESS, RECOVER), `master_t` enum (`M_CPU`, `M_DMA`), and `localparam` `MAX_WAIT_CYCLES = 15`.
- Sub-module `z80_arb_pick`: combinational winner selection from two reqs plus `last_owner`. It holds the macro-dependent logic.

## Test plan
- CPU read of 16'h0000 with memory default 8'h2A, `WAIT_CYCLES`=1 → strobes low exactly 2 cycles; `rdata`=8'h2A with `cpu_done` pulse at E3.
- DMA write 8'h5A to 16'h0020, then CPU read of 16'h0020 → `WR_L` low 2 cycles with `data_bus`=8'h5A; read returns 8'h5A.
- Both requesting continuously for 4 transactions:
  - Round-robin build: CPU, DMA, CPU, DMA.
  - Fixed-priority build: CPU ×4, no `dma_gnt`.
- `WAIT_CYCLES`=3 read of 16'h0001 → strobes low 4 cycles; `rdata`=8'hBB; next grant no earlier than E6.
- `rst_L` asserted in the second ACCESS cycle of a write → strobes high and `data_bus` `'z` immediately; no `done`; first request after reset is granted normally.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and sizing for the Z80 two-master memory arbiter.
package z80_bus_pkg;

  localparam int unsigned MAX_WAIT_CYCLES = 15;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DMA = 1'b1
  } master_t;

  // Request fields latched at grant and held for the whole transaction.
  typedef struct packed {
    master_t             owner;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } bus_req_t;

endpackage

// File: rtl/z80_arb_pick.sv
// Combinational winner selection between CPU and DMA requests.
// Build option: Z80_ARB_ROUND_ROBIN_EN alternates ties using last_owner_i;
// without it the CPU always wins a tie.
module z80_arb_pick
  import z80_bus_pkg::*;
(
`ifdef Z80_ARB_ROUND_ROBIN_EN
  input  master_t last_owner_i,
`endif
  input  logic    cpu_req_i,
  input  logic    dma_req_i,
  output master_t winner_c_o
);

  // Single requester wins; ties resolved by build option.
  always_comb begin
    winner_c_o = M_CPU;
    if (cpu_req_i && dma_req_i) begin
`ifdef Z80_ARB_ROUND_ROBIN_EN
      winner_c_o = (last_owner_i == M_CPU) ? M_DMA : M_CPU;
`else
      winner_c_o = M_CPU;
`endif
    end else if (dma_req_i) begin
      winner_c_o = M_DMA;
    end
  end

endmodule

// File: rtl/z80_mem_arbiter.sv
// Two-master (CPU/DMA) memory bus arbiter and strobe sequencer.
// Build option: Z80_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// instead of fixed CPU priority.
module z80_mem_arbiter
  import z80_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
)
(
  input  logic              clk,
  input  logic              rst_L,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic              MREQ_L,
  output logic              RD_L,
  output logic              WR_L,
  inout  wire  [ADDR_W-1:0] addr_bus,
  inout  wire  [DATA_W-1:0] data_bus
);

  if (WAIT_CYCLES == 0 || WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait
    $error("z80_mem_arbiter: WAIT_CYCLES must be in 1..15");
  end

  arb_state_t          state_q, state_d;
  bus_req_t            req_q, req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mreq_q, mreq_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic                dma_gnt_q, dma_gnt_d;
  logic                cpu_done_q, cpu_done_d;
  logic                dma_done_q, dma_done_d;
  logic                addr_oe_q, addr_oe_d;
  logic                data_oe_q, data_oe_d;
  master_t             winner_c;

`ifdef Z80_ARB_ROUND_ROBIN_EN
  master_t             last_owner_q, last_owner_d;
`endif

  z80_arb_pick u_pick (
`ifdef Z80_ARB_ROUND_ROBIN_EN
    .last_owner_i (last_owner_q),
`endif
    .cpu_req_i    (cpu_req),
    .dma_req_i    (dma_req),
    .winner_c_o   (winner_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, transaction latching and registered-output next values.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef Z80_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_d     = ACCESS;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          req_d.owner = winner_c;
          if (winner_c == M_CPU) begin
            req_d.we    = cpu_we;
            req_d.addr  = cpu_addr;
            req_d.wdata = cpu_wdata;
          end else begin
            req_d.we    = dma_we;
            req_d.addr  = dma_addr;
            req_d.wdata = dma_wdata;
          end
`ifdef Z80_ARB_ROUND_ROBIN_EN
          last_owner_d = winner_c;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RECOVER;
          if (!req_q.we) rdata_d = data_bus;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so derive them from the next state.
    mreq_d     = (state_d != ACCESS);
    rd_d       = !((state_d == ACCESS) && !req_d.we);
    wr_d       = !((state_d == ACCESS) && req_d.we);
    cpu_gnt_d  = (state_d != IDLE) && (req_d.owner == M_CPU);
    dma_gnt_d  = (state_d != IDLE) && (req_d.owner == M_DMA);
    cpu_done_d = (state_d == RECOVER) && (req_d.owner == M_CPU);
    dma_done_d = (state_d == RECOVER) && (req_d.owner == M_DMA);
    addr_oe_d  = (state_d != IDLE);
    data_oe_d  = (state_d == ACCESS) && req_d.we;
  end

  // Datapath and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      req_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      mreq_q     <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      cpu_gnt_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      addr_oe_q  <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      mreq_q     <= mreq_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cpu_gnt_q  <= cpu_gnt_d;
      dma_gnt_q  <= dma_gnt_d;
      cpu_done_q <= cpu_done_d;
      dma_done_q <= dma_done_d;
      addr_oe_q  <= addr_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

`ifdef Z80_ARB_ROUND_ROBIN_EN
  // Previous owner; reset to DMA so the CPU takes the first tie.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) last_owner_q <= M_DMA;
    else        last_owner_q <= last_owner_d;
  end
`endif

  assign MREQ_L   = mreq_q;
  assign RD_L     = rd_q;
  assign WR_L     = wr_q;
  assign cpu_gnt  = cpu_gnt_q;
  assign dma_gnt  = dma_gnt_q;
  assign cpu_done = cpu_done_q;
  assign dma_done = dma_done_q;
  assign rdata    = rdata_q;
  assign addr_bus = addr_oe_q ? req_q.addr  : {ADDR_W{1'bz}};
  assign data_bus = data_oe_q ? req_q.wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Bench for z80_mem_arbiter: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances,
// each with a byte-wide registered-read memory model.
module tb_z80_mem_arbiter;
  import z80_bus_pkg::*;

  typedef struct packed {
    master_t    m;
    logic [7:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_L;
  logic mem_clr_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // WAIT_CYCLES=1 instance signals
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_done, dma_gnt, dma_done;
  logic [7:0]  rdata;
  logic        MREQ_L, RD_L, WR_L;
  wire  [15:0] addr_bus;
  wire  [7:0]  data_bus;

  // WAIT_CYCLES=3 instance signals
  logic        cpu_req3, cpu_we3, dma_req3, dma_we3;
  logic [15:0] cpu_addr3, dma_addr3;
  logic [7:0]  cpu_wdata3, dma_wdata3;
  logic        cpu_gnt3, cpu_done3, dma_gnt3, dma_done3;
  logic [7:0]  rdata3;
  logic        MREQ_L3, RD_L3, WR_L3;
  wire  [15:0] addr_bus3;
  wire  [7:0]  data_bus3;

  always #5 clk = ~clk;

  z80_mem_arbiter #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_L(rst_L),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done),
    .rdata(rdata), .MREQ_L(MREQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .addr_bus(addr_bus), .data_bus(data_bus)
  );

  z80_mem_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_L(rst_L),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_gnt(cpu_gnt3), .cpu_done(cpu_done3),
    .dma_req(dma_req3), .dma_we(dma_we3), .dma_addr(dma_addr3), .dma_wdata(dma_wdata3),
    .dma_gnt(dma_gnt3), .dma_done(dma_done3),
    .rdata(rdata3), .MREQ_L(MREQ_L3), .RD_L(RD_L3), .WR_L(WR_L3),
    .addr_bus(addr_bus3), .data_bus(data_bus3)
  );

  // Memory models: read data registered one clock after RD_L seen low.
  logic [7:0] mem  [65536];
  logic [7:0] mem3 [65536];
  logic [7:0] mem_rd_q, mem3_rd_q;

  always @(posedge clk) begin
    if (!mem_clr_n) begin
      for (int i = 0; i < 65536; i++) begin
        mem[i]  <= 8'h2A;
        mem3[i] <= 8'h2A;
      end
      mem3[1] <= 8'hBB;
    end else begin
      if (!MREQ_L && !RD_L)   mem_rd_q  <= mem[addr_bus];
      if (!MREQ_L && !WR_L)   mem[addr_bus] <= data_bus;
      if (!MREQ_L3 && !RD_L3) mem3_rd_q <= mem3[addr_bus3];
      if (!MREQ_L3 && !WR_L3) mem3[addr_bus3] <= data_bus3;
    end
  end

  assign data_bus  = (!MREQ_L && !RD_L)   ? mem_rd_q  : 8'hzz;
  assign data_bus3 = (!MREQ_L3 && !RD_L3) ? mem3_rd_q : 8'hzz;

  // Drive one transaction on the WAIT_CYCLES=1 instance and observe it.
  task automatic run_txn(input master_t m, input logic we, input logic [15:0] a,
                         input logic [7:0] d, output int low_cyc, output int done_at,
                         output logic [7:0] rd_seen, output int wd_ok);
    low_cyc = 0; done_at = 0; rd_seen = 8'h00; wd_ok = 0;
    if (m == M_CPU) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end else begin
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!MREQ_L) low_cyc++;
      if (!WR_L && data_bus === d) wd_ok++;
      if ((m == M_CPU && cpu_done) || (m == M_DMA && dma_done)) begin
        done_at = c;
        rd_seen = rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] z16;
    logic [7:0]  z8;
    z16 = 16'hzzzz;
    z8  = 8'hzz;
    total++; if ({MREQ_L, RD_L, WR_L} !== 3'b111) begin bad++; $display("FAIL reset_strobes: got %b want 111", {MREQ_L, RD_L, WR_L}); end
    total++; if ({cpu_gnt, cpu_done, dma_gnt, dma_done} !== 4'b0000) begin bad++; $display("FAIL reset_gnt_done: got %b want 0000", {cpu_gnt, cpu_done, dma_gnt, dma_done}); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    total++; if (addr_bus !== z16) begin bad++; $display("FAIL reset_addr_bus: got %h want zzzz", addr_bus); end
    total++; if (data_bus !== z8) begin bad++; $display("FAIL reset_data_bus: got %h want zz", data_bus); end
  endtask

  task automatic test_cpu_read();
    int low, done_at, wd;
    logic [7:0] rd;
    exp_t e;
    sb.push_back('{m: M_CPU, rd: 8'h2A});
    run_txn(M_CPU, 1'b0, 16'h0000, 8'h00, low, done_at, rd, wd);
    e = sb.pop_front();
    total++; if (done_at !== 3) begin bad++; $display("FAIL cpu_read_done_cycle: got %0d want 3", done_at); end
    total++; if (low !== 2) begin bad++; $display("FAIL cpu_read_strobe_low: got %0d want 2", low); end
    total++; if (rd !== e.rd) begin bad++; $display("FAIL cpu_read_rdata: got %h want %h", rd, e.rd); end
    @(negedge clk);
    total++; if ({cpu_done, cpu_gnt} !== 2'b00) begin bad++; $display("FAIL cpu_read_pulse_end: got %b want 00", {cpu_done, cpu_gnt}); end
    total++; if (rdata !== e.rd) begin bad++; $display("FAIL cpu_read_rdata_hold: got %h want %h", rdata, e.rd); end
  endtask

  task automatic test_dma_write_cpu_read();
    int low, done_at, wd;
    logic [7:0] rd;
    exp_t e;
    run_txn(M_DMA, 1'b1, 16'h0020, 8'h5A, low, done_at, rd, wd);
    total++; if (done_at !== 3) begin bad++; $display("FAIL dma_write_done_cycle: got %0d want 3", done_at); end
    total++; if (low !== 2) begin bad++; $display("FAIL dma_write_strobe_low: got %0d want 2", low); end
    total++; if (wd !== 2) begin bad++; $display("FAIL dma_write_data_bus: got %0d cycles want 2", wd); end
    @(negedge clk);
    sb.push_back('{m: M_CPU, rd: 8'h5A});
    run_txn(M_CPU, 1'b0, 16'h0020, 8'h00, low, done_at, rd, wd);
    e = sb.pop_front();
    total++; if (rd !== e.rd) begin bad++; $display("FAIL cpu_readback_rdata: got %h want %h", rd, e.rd); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, dma_gnt_cyc;
    master_t got;
    exp_t e;
    rst_L = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
`ifdef Z80_ARB_ROUND_ROBIN_EN
    sb.push_back('{m: M_CPU, rd: 8'h00});
    sb.push_back('{m: M_DMA, rd: 8'h00});
    sb.push_back('{m: M_CPU, rd: 8'h00});
    sb.push_back('{m: M_DMA, rd: 8'h00});
`else
    for (int k = 0; k < 4; k++) sb.push_back('{m: M_CPU, rd: 8'h00});
`endif
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    dma_we = 1'b0; dma_addr = 16'h0020;
    n = 0; dma_gnt_cyc = 0;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cpu_req = 1'b1; dma_req = 1'b1;
      if (dma_gnt) dma_gnt_cyc++;
      if (cpu_done || dma_done) begin
        got = cpu_done ? M_CPU : M_DMA;
        e = sb.pop_front();
        total++; if (got !== e.m) begin bad++; $display("FAIL tie_owner_%0d: got %0d want %0d", n, got, e.m); end
        if (cpu_done) cpu_req = 1'b0;
        if (dma_done) dma_req = 1'b0;
        n++;
        if (n == 4) break;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    total++; if (n !== 4) begin bad++; $display("FAIL tie_count: got %0d want 4", n); end
`ifndef Z80_ARB_ROUND_ROBIN_EN
    total++; if (dma_gnt_cyc !== 0) begin bad++; $display("FAIL tie_no_dma_gnt: got %0d want 0", dma_gnt_cyc); end
`endif
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int low, done_at, wd, stray;
    logic [7:0] rd;
    logic [15:0] z16;
    logic [7:0]  z8;
    exp_t e;
    z16 = 16'hzzzz;
    z8  = 8'hzz;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0040; dma_wdata = 8'h77;
    @(negedge clk);
    @(negedge clk);
    total++; if (WR_L !== 1'b0) begin bad++; $display("FAIL mid_pre_wr_l: got %b want 0", WR_L); end
    rst_L = 1'b0;
    #1;
    total++; if ({MREQ_L, RD_L, WR_L} !== 3'b111) begin bad++; $display("FAIL mid_strobes: got %b want 111", {MREQ_L, RD_L, WR_L}); end
    total++; if (data_bus !== z8) begin bad++; $display("FAIL mid_data_bus: got %h want zz", data_bus); end
    total++; if (addr_bus !== z16) begin bad++; $display("FAIL mid_addr_bus: got %h want zzzz", addr_bus); end
    dma_req = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dma_done || cpu_done || dma_gnt) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", stray); end
    sb.push_back('{m: M_CPU, rd: 8'h2A});
    run_txn(M_CPU, 1'b0, 16'h0000, 8'h00, low, done_at, rd, wd);
    e = sb.pop_front();
    total++; if (done_at !== 3) begin bad++; $display("FAIL mid_after_done_cycle: got %0d want 3", done_at); end
    total++; if (rd !== e.rd) begin bad++; $display("FAIL mid_after_rdata: got %h want %h", rd, e.rd); end
    @(negedge clk);
  endtask

  task automatic test_wait3();
    int low, done_at, dones;
    logic [7:0] rd;
    logic g6, g7;
    exp_t e;
    low = 0; done_at = 0; dones = 0; rd = 8'h00; g6 = 1'b1; g7 = 1'b0;
    sb.push_back('{m: M_CPU, rd: 8'hBB});
    cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 16'h0001;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c <= 5 && !MREQ_L3) low++;
      if (cpu_done3) begin
        dones++;
        if (done_at == 0) begin done_at = c; rd = rdata3; end
      end
      if (c == 6) g6 = cpu_gnt3;
      if (c == 7) begin g7 = cpu_gnt3; cpu_req3 = 1'b0; end
    end
    cpu_req3 = 1'b0;
    e = sb.pop_front();
    total++; if (low !== 4) begin bad++; $display("FAIL w3_strobe_low: got %0d want 4", low); end
    total++; if (done_at !== 5) begin bad++; $display("FAIL w3_done_cycle: got %0d want 5", done_at); end
    total++; if (rd !== e.rd) begin bad++; $display("FAIL w3_rdata: got %h want %h", rd, e.rd); end
    total++; if (g6 !== 1'b0) begin bad++; $display("FAIL w3_no_early_gnt: got %b want 0", g6); end
    total++; if (g7 !== 1'b1) begin bad++; $display("FAIL w3_gnt_at_e6: got %b want 1", g7); end
    total++; if (dones !== 2) begin bad++; $display("FAIL w3_done_count: got %0d want 2", dones); end
  endtask

  initial begin
    rst_L = 1'b0; mem_clr_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cpu_req3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
    dma_req3 = 1'b0; dma_we3 = 1'b0; dma_addr3 = '0; dma_wdata3 = '0;
    repeat (3) @(negedge clk);
    rst_L = 1'b1; mem_clr_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_dma_write_cpu_read();
    test_back_to_back();
    test_reset_mid();
    test_wait3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
